sm83_irq_ctl: RTL and testbench
===============================

# sm83_irq_ctl

Interrupt controller and dispatch sequencer for the SM83 core. Holds the master interrupt enable (IME) and its one-instruction EI delay, and prioritises pending IE/IF requests at instruction boundaries. On a take it stalls the core for a 5-M-cycle dispatch: two waits, SP-decrement pushes of PC high/low, then a vector load. Sits beside the execute sequencer and drives the core's SP/PC/memory-write controls while dispatching.

## Interface
Parameters: none. Request bit order: 0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad.
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- m_tick  in  1  one-clk strobe per M-cycle; all state changes except reset and if_clr timing qualify on it
- instr_boundary  in  1  core is at an opcode-fetch decision point; held high every M-cycle while halted
- if_req  in  5  IF request flags, level
- ie  in  5  IE register bits [4:0]
- ei_pulse  in  1  EI executed; sampled with m_tick
- di_pulse  in  1  DI executed; sampled with m_tick
- reti_pulse  in  1  RETI executed; sampled with m_tick
- pc  in  16  current PC
- sp  in  16  current SP; the core updates it on m_tick when sp_dec is high
- ime  out  1  registered IME
- halt_wake  out  1  combinational |(if_req & ie), independent of IME
- core_stall  out  1  high in every non-IDLE state
- sp_dec  out  1  core decrements SP on m_tick
- mem_we  out  1  write request for the current M-cycle
- mem_addr  out  16  write address (= sp)
- mem_wdata  out  8  write data
- pc_load  out  1  core loads pc_vec into PC on m_tick
- pc_vec  out  16  16'h0040 + 8*idx
- if_clr  out  5  one-hot IF clear, one clk wide

## Operation
- States: IDLE, W1, W2, PUSH_HI, PUSH_LO, JUMP. Advance one state per m_tick: W1→W2→PUSH_HI→PUSH_LO→JUMP→IDLE.
- ime_eff = ime | ime_pend, using registered values only.
- take = IDLE & m_tick & instr_boundary & ime_eff & |(if_req & ie).
- On take:
  - idx is latched as the lowest set bit of if_req & ie.
  - ime and ime_pend clear.
  - The state goes to W1.
  - if_clr = 1<<idx for exactly the one clk following the edge.
- IME updates on an m_tick with no take, in priority order:
  1. di_pulse: clear ime and ime_pend.
  2. reti_pulse: ime set.
  3. ei_pulse: ime_pend set.
  4. instr_boundary & ime_pend: ime set, ime_pend cleared.
- Consequences: EI sampled on a boundary tick is not effective at that tick. It is effective at the next boundary, so exactly one instruction executes after EI.
- State outputs are combinational; any output not listed for a state is 0.
  - W1: core_stall.
  - W2: core_stall, sp_dec.
  - PUSH_HI: core_stall, sp_dec, mem_we, mem_addr = sp, mem_wdata = pc[15:8].
  - PUSH_LO: core_stall, mem_we, mem_addr = sp, mem_wdata = pc[7:0].
  - JUMP: core_stall, pc_load, pc_vec from latched idx.
- PC must not change during dispatch. SP is 16-bit and wraps (0x0000 - 1 = 0xFFFF).
- Outside PUSH_HI/PUSH_LO, mem_addr and mem_wdata are 0. Outside JUMP, pc_vec is 0.
- IME pulses arriving during dispatch are ignored.

## Timing
- Reset (asynchronous): state IDLE, ime = 0, ime_pend = 0, idx = 0, if_clr = 0; every output is 0 except halt_wake, which is combinational.
- Latency: the take tick is followed by 5 stalled M-cycles. pc_load is presented on the 5th tick after take; the first instruction fetch is at the vector in the next M-cycle.
- if_req dropping or ie changing after take does not alter idx or the sequence.
- Simultaneous requests: lowest index wins; the others stay pending in IF.
- Reset mid-dispatch: immediate IDLE; no further mem_we or pc_load.
- No m_tick: the state holds indefinitely; the outputs for the current state stay asserted.

## Test plan
- Reset: drive rst_n low mid-sequence → ime=0, core_stall=0, mem_we=0, pc_load=0, if_clr=0 with no clk edge.
- Priority dispatch:
  - Stimulus: reti_pulse, then boundary tick with ie=5'h1F, if_req=5'b10100, pc=16'h1234, sp=16'hFFFE.
  - Required: if_clr=5'b00100; ime=0.
  - Writes: PUSH_HI at 16'hFFFD data 8'h12; PUSH_LO at 16'hFFFC data 8'h34.
  - Vector: pc_load with pc_vec=16'h0050; stall exactly 5 ticks.
- EI delay: ei_pulse on a boundary tick with if_req=ie=5'b00001 → no take on that tick; take on the next boundary tick, vector 16'h0040.
- Masking:
  - ime=1, ie=0, if_req=5'h1F → no take, halt_wake=0.
  - Then ime=0, ie=5'h10, if_req=5'h10 → halt_wake=1, no take.
- DI versus EI: di_pulse and ei_pulse on the same tick → ime=0, ime_pend=0; no dispatch on later boundaries.
- Stall hold and wrap:
  - m_tick held low for 4 clk in PUSH_HI → outputs steady.
  - With sp=16'h0000 at take → writes land at 16'hFFFF and 16'hFFFE.

Source files
------------

// File: rtl/sm83_irq_ctl_if.sv
// sm83_irq_ctl_if
// Bundle between the SM83 core sequencer and the interrupt controller.
//   master : the core side. Drives the tick/boundary strobes, the IF/IE levels,
//            the EI/DI/RETI pulses and the current PC/SP. Receives the
//            dispatch controls.
//   slave  : the interrupt controller. Drives ime, halt_wake, core_stall,
//            sp_dec, the memory write (mem_we/mem_addr/mem_wdata), the vector
//            load (pc_load/pc_vec) and the one-hot if_clr.
interface sm83_irq_ctl_if;
    logic        m_tick;
    logic        instr_boundary;
    logic [4:0]  if_req;
    logic [4:0]  ie;
    logic        ei_pulse;
    logic        di_pulse;
    logic        reti_pulse;
    logic [15:0] pc;
    logic [15:0] sp;

    logic        ime;
    logic        halt_wake;
    logic        core_stall;
    logic        sp_dec;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        pc_load;
    logic [15:0] pc_vec;
    logic [4:0]  if_clr;

    modport master (
        output m_tick, instr_boundary, if_req, ie, ei_pulse, di_pulse,
               reti_pulse, pc, sp,
        input  ime, halt_wake, core_stall, sp_dec, mem_we, mem_addr,
               mem_wdata, pc_load, pc_vec, if_clr
    );

    modport slave (
        input  m_tick, instr_boundary, if_req, ie, ei_pulse, di_pulse,
               reti_pulse, pc, sp,
        output ime, halt_wake, core_stall, sp_dec, mem_we, mem_addr,
               mem_wdata, pc_load, pc_vec, if_clr
    );
endinterface

// File: rtl/sm83_irq_ctl.sv
// sm83_irq_ctl
// Interrupt master enable (with the one-instruction EI delay), IE/IF
// prioritisation at instruction boundaries, and the 5-M-cycle dispatch
// sequence: W1, W2, PUSH_HI, PUSH_LO, JUMP.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : sm83_irq_ctl_if.slave (core strobes/levels in, dispatch controls out)
module sm83_irq_ctl (
    input  logic                 clk,
    input  logic                 rst_n,
    sm83_irq_ctl_if.slave        bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W1      = 3'd1,
        S_W2      = 3'd2,
        S_PUSH_HI = 3'd3,
        S_PUSH_LO = 3'd4,
        S_JUMP    = 3'd5
    } state_t;

    // Index of the lowest set request bit (VBlank has the highest priority).
    function automatic logic [2:0] lowest_idx(input logic [4:0] req);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t      state_q, state_d;
    logic        ime_q, ime_d;
    logic        ime_pend_q, ime_pend_d;
    logic [2:0]  idx_q, idx_d;
    logic [4:0]  if_clr_q, if_clr_d;

    logic [4:0]  pend_s;
    logic        take_s;

    logic        core_stall_s;
    logic        sp_dec_s;
    logic        mem_we_s;
    logic [15:0] mem_addr_s;
    logic [7:0]  mem_wdata_s;
    logic        pc_load_s;
    logic [15:0] pc_vec_s;

    assign pend_s = bus.if_req & bus.ie;
    // ime_pend counts as enabled so the boundary after EI can take directly.
    assign take_s = (state_q == S_IDLE) && bus.m_tick && bus.instr_boundary &&
                    (ime_q || ime_pend_q) && (|pend_s);

    // Next-state, IME and vector-index logic.
    always_comb begin
        state_d    = state_q;
        ime_d      = ime_q;
        ime_pend_d = ime_pend_q;
        idx_d      = idx_q;
        if_clr_d   = 5'b00000;
        if (take_s) begin
            state_d    = S_W1;
            ime_d      = 1'b0;
            ime_pend_d = 1'b0;
            idx_d      = lowest_idx(pend_s);
            if_clr_d   = 5'b00001 << lowest_idx(pend_s);
        end else if (bus.m_tick) begin
            case (state_q)
                S_IDLE: begin
                    // IME pulses only act in IDLE; during dispatch they are dropped.
                    if (bus.di_pulse) begin
                        ime_d      = 1'b0;
                        ime_pend_d = 1'b0;
                    end else if (bus.reti_pulse) begin
                        ime_d = 1'b1;
                    end else if (bus.ei_pulse) begin
                        ime_pend_d = 1'b1;
                    end else if (bus.instr_boundary && ime_pend_q) begin
                        ime_d      = 1'b1;
                        ime_pend_d = 1'b0;
                    end else begin
                        ime_d = ime_q;
                    end
                end
                S_W1:      state_d = S_W2;
                S_W2:      state_d = S_PUSH_HI;
                S_PUSH_HI: state_d = S_PUSH_LO;
                S_PUSH_LO: state_d = S_JUMP;
                S_JUMP:    state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ime_q      <= 1'b0;
            ime_pend_q <= 1'b0;
            idx_q      <= 3'd0;
            if_clr_q   <= 5'b00000;
        end else begin
            state_q    <= state_d;
            ime_q      <= ime_d;
            ime_pend_q <= ime_pend_d;
            idx_q      <= idx_d;
            if_clr_q   <= if_clr_d;
        end
    end

    // Per-state dispatch controls; SP is decremented in W2 and PUSH_HI so each
    // push addresses the already-decremented SP.
    always_comb begin
        core_stall_s = 1'b0;
        sp_dec_s     = 1'b0;
        mem_we_s     = 1'b0;
        mem_addr_s   = 16'h0000;
        mem_wdata_s  = 8'h00;
        pc_load_s    = 1'b0;
        pc_vec_s     = 16'h0000;
        case (state_q)
            S_IDLE: begin
                core_stall_s = 1'b0;
            end
            S_W1: begin
                core_stall_s = 1'b1;
            end
            S_W2: begin
                core_stall_s = 1'b1;
                sp_dec_s     = 1'b1;
            end
            S_PUSH_HI: begin
                core_stall_s = 1'b1;
                sp_dec_s     = 1'b1;
                mem_we_s     = 1'b1;
                mem_addr_s   = bus.sp;
                mem_wdata_s  = bus.pc[15:8];
            end
            S_PUSH_LO: begin
                core_stall_s = 1'b1;
                mem_we_s     = 1'b1;
                mem_addr_s   = bus.sp;
                mem_wdata_s  = bus.pc[7:0];
            end
            S_JUMP: begin
                core_stall_s = 1'b1;
                pc_load_s    = 1'b1;
                // 0x40 + 8*idx; idx*8 never reaches bit 6, so this is a plain OR.
                pc_vec_s     = {9'b0_0000_0000, 1'b1, idx_q, 3'b000};
            end
            default: begin
                core_stall_s = 1'b0;
            end
        endcase
    end

    assign bus.ime        = ime_q;
    assign bus.halt_wake  = |pend_s;
    assign bus.core_stall = core_stall_s;
    assign bus.sp_dec     = sp_dec_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.pc_load    = pc_load_s;
    assign bus.pc_vec     = pc_vec_s;
    assign bus.if_clr     = if_clr_q;

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// tb_sm83_irq_ctl
// Drives sm83_irq_ctl as a small core model (SP decrement on sp_dec, PC load
// on pc_load, IF clear on if_clr) and scoreboards the dispatch events.
module tb_sm83_irq_ctl;

    localparam int K_CLR = 0;
    localparam int K_WR  = 1;
    localparam int K_VEC = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  data;
    } sb_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   stall_cnt;
    sb_t  sb_q[$];

    sm83_irq_ctl_if bus();

    sm83_irq_ctl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Queue an expected dispatch event.
    task automatic sb_push(input int kind, input logic [15:0] addr, input logic [7:0] data);
        sb_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Compare an observed dispatch event against the oldest expected one.
    task automatic sb_pop(input int kind, input logic [15:0] addr, input logic [7:0] data);
        sb_t e;
        check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("sb_kind", 32'(kind), 32'(e.kind));
            check_eq("sb_addr", 32'(addr), 32'(e.addr));
            check_eq("sb_data", 32'(data), 32'(e.data));
        end
    endtask

    // One M-cycle: tick strobe for one clk, then one idle clk. Starts and ends at posedge+1.
    task automatic mcycle(input logic bnd, input logic ei, input logic di, input logic reti);
        logic        dec;
        logic        ld;
        logic [15:0] vec;
        logic        clr;
        bus.m_tick         = 1'b1;
        bus.instr_boundary = bnd;
        bus.ei_pulse       = ei;
        bus.di_pulse       = di;
        bus.reti_pulse     = reti;
        @(negedge clk);
        dec = bus.sp_dec;
        ld  = bus.pc_load;
        vec = bus.pc_vec;
        clr = 1'b0;
        if (bus.core_stall) stall_cnt++;
        if (bus.mem_we) sb_pop(K_WR, bus.mem_addr, bus.mem_wdata);
        if (bus.pc_load) sb_pop(K_VEC, bus.pc_vec, 8'h00);
        @(posedge clk);
        #1;
        bus.m_tick         = 1'b0;
        bus.instr_boundary = 1'b0;
        bus.ei_pulse       = 1'b0;
        bus.di_pulse       = 1'b0;
        bus.reti_pulse     = 1'b0;
        if (dec) bus.sp = bus.sp - 16'h0001;
        if (ld) bus.pc = vec;
        if (bus.if_clr != 5'b00000) begin
            sb_pop(K_CLR, {11'b0, bus.if_clr}, 8'h00);
            bus.if_req = bus.if_req & ~bus.if_clr;
            clr = 1'b1;
        end
        @(posedge clk);
        #1;
        if (clr) check_eq("if_clr_width", 32'(bus.if_clr), 32'd0);
    endtask

    // Five stalled M-cycles after a take, then confirm the core is released.
    task automatic finish_dispatch(input logic [15:0] exp_pc, input logic [15:0] exp_sp);
        repeat (5) mcycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("stall_ticks", 32'(stall_cnt), 32'd5);
        check_eq("stall_released", 32'(bus.core_stall), 32'd0);
        check_eq("pc_after", 32'(bus.pc), 32'(exp_pc));
        check_eq("sp_after", 32'(bus.sp), 32'(exp_sp));
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        stall_cnt = 0;
        rst_n     = 1'b0;
        bus.m_tick         = 1'b0;
        bus.instr_boundary = 1'b0;
        bus.if_req         = 5'b00000;
        bus.ie             = 5'b00000;
        bus.ei_pulse       = 1'b0;
        bus.di_pulse       = 1'b0;
        bus.reti_pulse     = 1'b0;
        bus.pc             = 16'h0100;
        bus.sp             = 16'hFFFE;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ime", 32'(bus.ime), 32'd0);
        check_eq("rst_stall", 32'(bus.core_stall), 32'd0);
        check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_eq("rst_pc_load", 32'(bus.pc_load), 32'd0);
        check_eq("rst_if_clr", 32'(bus.if_clr), 32'd0);
        check_eq("rst_pc_vec", 32'(bus.pc_vec), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Priority dispatch: Timer beats Joypad, ie dropped after take.
        bus.pc = 16'h1234;
        bus.sp = 16'hFFFE;
        bus.ie = 5'h1F;
        bus.if_req = 5'b10100;
        mcycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("reti_ime", 32'(bus.ime), 32'd1);
        sb_push(K_CLR, 16'h0004, 8'h00);
        sb_push(K_WR, 16'hFFFD, 8'h12);
        sb_push(K_WR, 16'hFFFC, 8'h34);
        sb_push(K_VEC, 16'h0050, 8'h00);
        mcycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("take_ime", 32'(bus.ime), 32'd0);
        check_eq("if_left_pending", 32'(bus.if_req), 32'h10);
        bus.ie = 5'h00;
        stall_cnt = 0;
        finish_dispatch(16'h0050, 16'hFFFC);
        bus.if_req = 5'b00000;

        // EI delay: not effective on its own boundary tick.
        bus.pc = 16'h0200;
        bus.sp = 16'hD000;
        bus.ie = 5'b00001;
        bus.if_req = 5'b00001;
        mcycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("ei_ime", 32'(bus.ime), 32'd0);
        check_eq("ei_no_take", 32'(bus.core_stall), 32'd0);
        mcycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("ei_mid_no_take", 32'(bus.core_stall), 32'd0);
        sb_push(K_CLR, 16'h0001, 8'h00);
        sb_push(K_WR, 16'hCFFF, 8'h02);
        sb_push(K_WR, 16'hCFFE, 8'h00);
        sb_push(K_VEC, 16'h0040, 8'h00);
        mcycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("ei_take_ime", 32'(bus.ime), 32'd0);
        stall_cnt = 0;
        finish_dispatch(16'h0040, 16'hCFFE);

        // Masking: IME set but IE clear.
        bus.ie = 5'h00;
        bus.if_req = 5'h1F;
        mcycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("mask_ime", 32'(bus.ime), 32'd1);
        check_eq("mask_halt_wake0", 32'(bus.halt_wake), 32'd0);
        mcycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("mask_no_take", 32'(bus.core_stall), 32'd0);
        mcycle(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("di_ime", 32'(bus.ime), 32'd0);
        bus.ie = 5'h10;
        bus.if_req = 5'h10;
        #1;
        check_eq("halt_wake1", 32'(bus.halt_wake), 32'd1);
        mcycle(1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("ime0_no_take", 32'(bus.core_stall), 32'd0);

        // DI and EI on the same tick: DI wins, no later dispatch.
        bus.ie = 5'b00001;
        bus.if_req = 5'b00001;
        mcycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("di_ei_ime", 32'(bus.ime), 32'd0);
        for (int i = 0; i < 2; i++) begin
            mcycle(1'b1, 1'b0, 1'b0, 1'b0);
            check_eq("di_ei_no_take", 32'(bus.core_stall), 32'd0);
        end

        // SP wrap and stall hold in PUSH_HI.
        bus.pc = 16'h4321;
        bus.sp = 16'h0000;
        bus.ie = 5'b00010;
        bus.if_req = 5'b00010;
        mcycle(1'b0, 1'b0, 1'b0, 1'b1);
        sb_push(K_CLR, 16'h0002, 8'h00);
        sb_push(K_WR, 16'hFFFF, 8'h43);
        sb_push(K_WR, 16'hFFFE, 8'h21);
        sb_push(K_VEC, 16'h0048, 8'h00);
        mcycle(1'b1, 1'b0, 1'b0, 1'b0);
        stall_cnt = 0;
        repeat (2) mcycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("hold_mem_we", 32'(bus.mem_we), 32'd1);
            check_eq("hold_addr", 32'(bus.mem_addr), 32'hFFFF);
            check_eq("hold_wdata", 32'(bus.mem_wdata), 32'h43);
            check_eq("hold_sp_dec", 32'(bus.sp_dec), 32'd1);
            @(posedge clk);
            #1;
        end
        repeat (3) mcycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("stall_ticks", 32'(stall_cnt), 32'd5);
        check_eq("wrap_pc", 32'(bus.pc), 32'h0048);
        check_eq("wrap_sp", 32'(bus.sp), 32'hFFFE);
        check_eq("wrap_drained", 32'(sb_q.size()), 32'd0);

        // Reset mid-dispatch: immediate IDLE, no further writes or vector.
        bus.pc = 16'h1000;
        bus.sp = 16'hC000;
        bus.ie = 5'b00001;
        bus.if_req = 5'b00001;
        mcycle(1'b0, 1'b0, 1'b0, 1'b1);
        sb_push(K_CLR, 16'h0001, 8'h00);
        mcycle(1'b1, 1'b0, 1'b0, 1'b0);
        mcycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("pre_rst_stall", 32'(bus.core_stall), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_ime", 32'(bus.ime), 32'd0);
        check_eq("arst_stall", 32'(bus.core_stall), 32'd0);
        check_eq("arst_mem_we", 32'(bus.mem_we), 32'd0);
        check_eq("arst_pc_load", 32'(bus.pc_load), 32'd0);
        check_eq("arst_if_clr", 32'(bus.if_clr), 32'd0);
        check_eq("arst_sp_dec", 32'(bus.sp_dec), 32'd0);
        @(posedge clk);
        #1;
        repeat (3) mcycle(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_stall", 32'(bus.core_stall), 32'd0);
        check_eq("post_rst_pc", 32'(bus.pc), 32'h1000);
        check_eq("post_rst_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
